// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue and its neighbouring pipeline stages.
package fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0,x0,0; the fetch stage resets to the same word.
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: enqueue side, flush, dequeue side and status.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
);
    logic                     in_valid;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_insn;
    logic                     flush;
    logic                     deq_ready;
    logic                     out_valid;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_insn;
    logic                     fetch_stall;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output in_valid, in_pc, in_insn, flush, deq_ready,
        input  out_valid, out_pc, out_insn, fetch_stall, count, overflow
    );

    modport slave (
        input  in_valid, in_pc, in_insn, flush, deq_ready,
        output out_valid, out_pc, out_insn, fetch_stall, count, overflow
    );
endinterface

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: one synchronous write port, one combinational read port.
module fetch_queue_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  fetch_entry_t     wdata,
    input  logic [AddrW-1:0] raddr,
    output fetch_entry_t     rdata
);
    fetch_entry_t mem [DEPTH];

    // Contents are qualified by the occupancy count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// First-word fall-through instruction buffer between fetch and decode, with flush and stall.
module fetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = fetch_queue_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSN = fetch_queue_pkg::NOP_INSN
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave q
);
    import fetch_queue_pkg::*;

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntStall = CntW'(DEPTH - 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            full, out_valid, deq, enq, drop;
    fetch_entry_t    wr_entry, rd_entry;

    assign full      = (count_q == CntFull);
    assign out_valid = (count_q != '0) && !q.flush;
    assign deq       = out_valid && q.deq_ready;
    // A dequeue in the same cycle frees the slot, so a full queue can still accept.
    assign enq       = q.in_valid && !q.flush && (!full || deq);
    assign drop      = q.in_valid && !q.flush && full && !deq;
    assign wr_entry  = '{pc: q.in_pc, insn: q.in_insn};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(enq) - CntW'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Stall one entry early: fetch already has one registered entry in flight.
    assign q.fetch_stall = (count_q >= CntStall) && !q.flush;
    assign q.out_valid   = out_valid;
    assign q.out_pc      = out_valid ? rd_entry.pc : '0;
    assign q.out_insn    = out_valid ? rd_entry.insn : NOP_INSN;
    assign q.count       = count_q;
    assign q.overflow    = overflow_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, async-reset sequences, random vs queue model.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(32)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .q   (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        fl;
        logic        dr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einsn;
        int          ecnt;
        logic        estall;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: a plain queue of entries plus a sticky error flag.
    logic [31:0] m_pc[$];
    logic [31:0] m_insn[$];
    logic        m_ovf;

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] insn,
                                input logic fl, input logic dr, input logic ev,
                                input logic [31:0] epc, input logic [31:0] einsn, input int ecnt,
                                input logic estall, input logic eovf);
        vec_t r;
        r.iv = iv; r.pc = pc; r.insn = insn; r.fl = fl; r.dr = dr;
        r.ev = ev; r.epc = epc; r.einsn = einsn; r.ecnt = ecnt;
        r.estall = estall; r.eovf = eovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] einsn, input int ecnt, input logic estall,
                            input logic eovf);
        chk({tag, ".out_valid"},   32'(fq.out_valid),   32'(ev));
        chk({tag, ".out_pc"},      fq.out_pc,           epc);
        chk({tag, ".out_insn"},    fq.out_insn,         einsn);
        chk({tag, ".count"},       32'(fq.count),       32'(ecnt));
        chk({tag, ".fetch_stall"}, 32'(fq.fetch_stall), 32'(estall));
        chk({tag, ".overflow"},    32'(fq.overflow),    32'(eovf));
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] insn,
                         input logic fl, input logic dr);
        fq.in_valid  = iv;
        fq.in_pc     = pc;
        fq.in_insn   = insn;
        fq.flush     = fl;
        fq.deq_ready = dr;
    endtask

    // Called just after a posedge: apply inputs, check mid-cycle, advance one clock.
    task automatic step(input string tag, input vec_t v);
        drive(v.iv, v.pc, v.insn, v.fl, v.dr);
        #3;
        chk_outs(tag, v.ev, v.epc, v.einsn, v.ecnt, v.estall, v.eovf);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 32'h0, NOP, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset with no clock edge: outputs must settle immediately.
        #2 rst = 1'b1;
        #1;
        chk_outs("reset", 1'b0, 32'h0, NOP, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with decode always ready.
        vecs.push_back(mk(1, 32'h00, 32'hA,   0, 1, 0, 32'h00, NOP,     0, 0, 0));
        vecs.push_back(mk(1, 32'h04, 32'hB,   0, 1, 1, 32'h00, 32'hA,   1, 0, 0));
        vecs.push_back(mk(1, 32'h08, 32'hC,   0, 1, 1, 32'h04, 32'hB,   1, 0, 0));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 1, 1, 32'h08, 32'hC,   1, 0, 0));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 0, 0, 32'h00, NOP,     0, 0, 0));
        // Fill, stall, then drain across the pointer wrap.
        vecs.push_back(mk(1, 32'h10, 32'h110, 0, 0, 0, 32'h00, NOP,     0, 0, 0));
        vecs.push_back(mk(1, 32'h14, 32'h114, 0, 0, 1, 32'h10, 32'h110, 1, 0, 0));
        vecs.push_back(mk(1, 32'h18, 32'h118, 0, 0, 1, 32'h10, 32'h110, 2, 0, 0));
        vecs.push_back(mk(1, 32'h1C, 32'h11C, 0, 0, 1, 32'h10, 32'h110, 3, 1, 0));
        vecs.push_back(mk(1, 32'h20, 32'h120, 0, 1, 1, 32'h10, 32'h110, 4, 1, 0));
        vecs.push_back(mk(1, 32'h24, 32'h124, 0, 1, 1, 32'h14, 32'h114, 4, 1, 0));
        vecs.push_back(mk(1, 32'h28, 32'h128, 0, 1, 1, 32'h18, 32'h118, 4, 1, 0));
        vecs.push_back(mk(1, 32'h2C, 32'h12C, 0, 1, 1, 32'h1C, 32'h11C, 4, 1, 0));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 1, 1, 32'h20, 32'h120, 4, 1, 0));
        // Flush at count 3 with concurrent enqueue and dequeue.
        vecs.push_back(mk(1, 32'h40, 32'h140, 1, 1, 0, 32'h00, NOP,     3, 0, 0));
        vecs.push_back(mk(1, 32'h80, 32'h180, 0, 0, 0, 32'h00, NOP,     0, 0, 0));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 0, 1, 32'h80, 32'h180, 1, 0, 0));
        // Overflow: fill, push while full, then push while full and draining.
        vecs.push_back(mk(1, 32'h84, 32'h184, 0, 0, 1, 32'h80, 32'h180, 1, 0, 0));
        vecs.push_back(mk(1, 32'h88, 32'h188, 0, 0, 1, 32'h80, 32'h180, 2, 0, 0));
        vecs.push_back(mk(1, 32'h8C, 32'h18C, 0, 0, 1, 32'h80, 32'h180, 3, 1, 0));
        vecs.push_back(mk(1, 32'h50, 32'h150, 0, 0, 1, 32'h80, 32'h180, 4, 1, 0));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 0, 1, 32'h80, 32'h180, 4, 1, 1));
        vecs.push_back(mk(1, 32'h54, 32'h154, 0, 1, 1, 32'h80, 32'h180, 4, 1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 1, 1, 32'h84, 32'h184, 4, 1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 1, 1, 32'h88, 32'h188, 3, 1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 1, 1, 32'h8C, 32'h18C, 2, 0, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 1, 1, 32'h54, 32'h154, 1, 0, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0,   0, 0, 0, 32'h00, NOP,     0, 0, 1));

        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

        // Async reset mid-stream with two entries queued.
        step("mid_a", mk(1, 32'h200, 32'h300, 0, 0, 0, 32'h0, NOP, 0, 0, 1));
        step("mid_b", mk(1, 32'h204, 32'h304, 0, 0, 1, 32'h200, 32'h300, 1, 0, 1));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("mid_pre.count", 32'(fq.count), 32'd2);
        reset_pulse();
        step("post_a", mk(1, 32'h100, 32'h400, 0, 0, 0, 32'h0, NOP, 0, 0, 0));
        step("post_b", mk(0, 32'h0, 32'h0, 0, 1, 1, 32'h100, 32'h400, 1, 0, 0));
        step("post_c", mk(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, NOP, 0, 0, 0));

        // Random traffic against the queue model.
        reset_pulse();
        m_pc.delete();
        m_insn.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        iv, fl, dr, ev, took;
            logic [31:0] pc, insn;
            int          n;
            iv   = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            dr   = ($urandom_range(0, 2) != 0);
            pc   = $urandom;
            insn = $urandom;
            n    = m_pc.size();
            ev   = (n != 0) && !fl;
            step($sformatf("rnd%0d", c),
                 mk(iv, pc, insn, fl, dr, ev, ev ? m_pc[0] : 32'h0, ev ? m_insn[0] : NOP,
                    n, (n >= DEPTH - 1) && !fl, m_ovf));
            if (fl) begin
                m_pc.delete();
                m_insn.delete();
            end else begin
                took = ev && dr;
                if (took) begin
                    void'(m_pc.pop_front());
                    void'(m_insn.pop_front());
                end
                if (iv) begin
                    if (n < DEPTH || took) begin
                        m_pc.push_back(pc);
                        m_insn.push_back(insn);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
